// File: rtl/matrix_rot_stream.sv
// Row-streamed NxN matrix rotator: buffers N rows, then drains the matrix rotated by k CCW quarter turns.
// Optional macro MATRIX_ROT_TRANSPOSE_EN adds in_xpose to rotate the transposed matrix instead.
module matrix_rot_stream #(
    parameter int unsigned N = 3,
    parameter int unsigned W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_row,
    input  logic [1:0]     in_rot,
    input  logic           in_dir,
`ifdef MATRIX_ROT_TRANSPOSE_EN
    input  logic           in_xpose,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_row,
    output logic           out_last,
    output logic           busy
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  buf_q [N][N];
    logic [CW-1:0] cnt_q;
    logic [1:0]    k_q;
    logic          in_acc, out_acc, at_last;
    logic [CW-1:0] sr, sc;
    logic [W-1:0]  elem;
`ifdef MATRIX_ROT_TRANSPOSE_EN
    logic          xp_q;
`endif

    assign at_last  = (cnt_q == LAST);
    assign in_acc   = in_valid && in_ready;
    assign out_acc  = out_valid && out_ready;
    assign out_last = out_valid && at_last;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && at_last) state_d = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready && at_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Row buffer, row counter and mode latched with row 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            k_q   <= 2'd0;
`ifdef MATRIX_ROT_TRANSPOSE_EN
            xp_q  <= 1'b0;
`endif
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    buf_q[r][c] <= '0;
                end
            end
        end else begin
            if (in_acc) begin
                for (int c = 0; c < N; c++) begin
                    buf_q[cnt_q][c] <= in_row[(N-1-c)*W +: W];
                end
                cnt_q <= at_last ? '0 : cnt_q + CW'(1);
            end else if (out_acc) begin
                cnt_q <= at_last ? '0 : cnt_q + CW'(1);
            end
            if (in_acc && (state_q == IDLE)) begin
                k_q  <= in_dir ? (2'd0 - in_rot) : in_rot;
`ifdef MATRIX_ROT_TRANSPOSE_EN
                xp_q <= in_xpose;
`endif
            end
        end
    end

    // Element select for output row cnt_q under k_q CCW quarter turns
    always_comb begin
        out_row = '0;
        sr      = '0;
        sc      = '0;
        elem    = '0;
        for (int c = 0; c < N; c++) begin
            case (k_q)
                2'd1:    begin sr = CW'(c);         sc = LAST - cnt_q;   end
                2'd2:    begin sr = LAST - cnt_q;   sc = LAST - CW'(c);  end
                2'd3:    begin sr = LAST - CW'(c);  sc = cnt_q;          end
                default: begin sr = cnt_q;          sc = CW'(c);         end
            endcase
`ifdef MATRIX_ROT_TRANSPOSE_EN
            elem = xp_q ? buf_q[sc][sr] : buf_q[sr][sc];
`else
            elem = buf_q[sr][sc];
`endif
            if (out_valid) out_row[(N-1-c)*W +: W] = elem;
        end
    end

endmodule

// File: doc/matrix_rot_stream.md
Name: matrix_rot_stream

Overview:
- Row-streamed NxN matrix rotator, the parametrised successor of the fixed 3x3 4-bit single-word rotator.
- Accepts one matrix row per beat over a valid/ready handshake and buffers all N rows.
- Applies a 0/90/180/270-degree rotation in either direction, then emits the rotated matrix row by row with backpressure.
- Sits between the matrix source and downstream matrix arithmetic blocks in the same datapath.

Parameters:
- N, 3, matrix dimension (rows = columns), N >= 2.
- W, 4, element width in bits (signed two's complement, passed through unmodified).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input row valid.
- in_ready  out  1  block can accept an input row.
- in_row  in  N*W  input row; column c at bits [(N-1-c)*W +: W], so column 0 is at the MSBs.
- in_rot  in  2  number of quarter turns; sampled only with row 0.
- in_dir  in  1  rotation direction; sampled only with row 0.
- out_valid  out  1  output row valid.
- out_ready  in  1  downstream accepts the output row.
- out_row  out  N*W  rotated output row, same column packing as in_row.
- out_last  out  1  high with output row N-1.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Effective CCW quarter-turn count: k = (in_dir==0) ? in_rot : (4-in_rot) mod 4.
- Output element C(r,c) is selected from input A by k:
  - k=0: C(r,c) = A(r,c).
  - k=1: C(r,c) = A(c, N-1-r).
  - k=2: C(r,c) = A(N-1-r, N-1-c).
  - k=3: C(r,c) = A(N-1-c, r).
- Rows arrive and leave in order r = 0..N-1.
- Storage: N x N x W buffer register, a row counter (clog2 N bits), a latched 2-bit k, and the state register.
- FSM states: IDLE, LOAD, DRAIN.
- IDLE:
  - in_ready = 1.
  - On in_valid: store row 0, latch k from in_rot/in_dir, row counter = 1, go to LOAD.
- LOAD:
  - in_ready = 1.
  - Each accepted beat stores row[cnt], cnt++.
  - When the beat storing row N-1 is accepted: cnt = 0, go to DRAIN.
  - in_rot/in_dir are ignored in LOAD.
- DRAIN:
  - in_ready = 0.
  - out_valid = 1; out_row = rotated row[cnt], computed combinationally from the buffer and latched k.
  - out_last = (cnt == N-1).
  - On out_ready: cnt++. If out_last, cnt = 0 and go to IDLE.
  - out_valid stays high and out_row stays stable while out_ready = 0.
- Latency: first output row is valid the cycle after row N-1 is accepted.
- Throughput: no input/output overlap; one matrix per 2N cycles minimum.
- out_row = 0 and out_last = 0 whenever out_valid = 0.
- Reset, whether idle or mid-load/mid-drain:
  - State IDLE, cnt 0, k 0, buffer cleared to 0.
  - Outputs: out_valid 0, busy 0, in_ready 1.
  - A partial matrix is discarded.
- in_valid asserted in DRAIN is not accepted (in_ready = 0); the source must hold the row.
- The last output beat and the next row 0 are never accepted in the same cycle; IDLE is reached first.

Optional Feature:
- Macro: MATRIX_ROT_TRANSPOSE_EN.
- Defined:
  - Adds port in_xpose (in, 1), sampled and latched with row 0 like in_rot.
  - When the latched value is 1, the rotation is applied to the transpose A'(r,c) = A(c,r) instead of A.
  - Transpose plus rotation covers all 8 dihedral orientations.
- Undefined:
  - Port in_xpose is absent and no transpose logic is built.
  - Behaviour is identical to in_xpose = 0.

Test Plan (N=3, W=4; input rows 0x123, 0x456, 0x789):
- Identity: dir=0, rot=0, out_ready=1 -> outputs 0x123, 0x456, 0x789; out_last on the third row; out_valid rises the cycle after the 3rd input beat.
- Rotation set:
  - dir=0, rot=1 -> 0x369, 0x258, 0x147.
  - dir=0, rot=2 -> 0x987, 0x654, 0x321.
  - dir=0, rot=3 -> 0x741, 0x852, 0x963.
  - dir=1, rot=1 -> 0x741, 0x852, 0x963.
- Mode latch: rot changes from 1 to 2 during rows 1-2 -> output still follows rot=1 (0x369...).
- Backpressure: dir=0, rot=2 with out_ready toggling 0,0,1,0,1,1 -> out_row held stable while stalled; sequence 0x987, 0x654, 0x321 intact; in_ready = 0 throughout DRAIN.
- Reset mid-operation:
  - Assert rst after row 1 -> in_ready = 1, busy = 0, out_valid = 0.
  - Then a new full matrix with rot=0 -> clean identity output.
- Transpose (macro defined): in_xpose=1, rot=0 -> 0x147, 0x258, 0x369.
